// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared types and sizing helpers for the PLL reset sequencer.
// Provides the sequencer state enum, default parameter values and width helpers.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        RELEASE   = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_t;

    localparam int unsigned DEF_NUM_DOMAINS      = 4;
    localparam int unsigned DEF_RST_PULSE_CYC    = 16;
    localparam int unsigned DEF_LOCK_STABLE_CYC  = 1024;
    localparam int unsigned DEF_LOCK_TIMEOUT_CYC = 125000;
    localparam int unsigned DEF_STAGGER_CYC      = 8;
    localparam int unsigned DEF_MAX_RETRIES      = 3;

    // Width of a counter that must hold values 0 .. n-1.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned max_u(
        input int unsigned a,
        input int unsigned b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous level.
// Ports: i_clk, i_rst_n (async active-low, resets to 0), i_d (async in), o_q (synced out).
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: pulses the PLL reset, debounces lock, releases domain
// resets in staggered order, re-sequences on lock loss, gives up after retries.
// Ports: refclk, rst_n (async low), pll_locked_i (async), restart_i,
//   pll_rst_o, domain_rst_n_o[NUM_DOMAINS], ready_o, fail_o, lol_event_o, retry_cnt_o.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS      = DEF_NUM_DOMAINS,
    parameter int unsigned RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
    parameter int unsigned LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
    parameter int unsigned LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
    parameter int unsigned STAGGER_CYC      = DEF_STAGGER_CYC,
    parameter int unsigned MAX_RETRIES      = DEF_MAX_RETRIES,
    localparam int unsigned CW = $clog2(MAX_RETRIES + 1)
) (
    input  logic                   refclk,
    input  logic                   rst_n,
    input  logic                   pll_locked_i,
    input  logic                   restart_i,
    output logic                   pll_rst_o,
    output logic [NUM_DOMAINS-1:0] domain_rst_n_o,
    output logic                   ready_o,
    output logic                   fail_o,
    output logic                   lol_event_o,
    output logic [CW-1:0]          retry_cnt_o
);

    localparam int unsigned PW = cnt_w(max_u(RST_PULSE_CYC, STAGGER_CYC));
    localparam int unsigned SW = cnt_w(LOCK_STABLE_CYC);
    localparam int unsigned TW = cnt_w(LOCK_TIMEOUT_CYC);

    localparam logic [PW-1:0] PULSE_LAST  = PW'(RST_PULSE_CYC - 1);
    localparam logic [PW-1:0] STAG_LAST   = PW'(STAGGER_CYC - 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE_CYC - 1);
    localparam logic [TW-1:0] TOUT_LAST   = TW'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] RETRY_MAX   = CW'(MAX_RETRIES);
    localparam logic [NUM_DOMAINS-1:0] DOM_ONE = NUM_DOMAINS'(1);

    logic                   w_lock_s;
    logic                   w_exhausted;

    state_t                 r_state;
    logic [PW-1:0]          r_cnt;
    logic [SW-1:0]          r_stable;
    logic [TW-1:0]          r_timeout;
    logic [CW-1:0]          r_retry;
    logic                   r_pll_rst;
    logic [NUM_DOMAINS-1:0] r_dom;
    logic                   r_ready;
    logic                   r_fail;
    logic                   r_lol;

    sync_2ff u_lock_sync (
        .i_clk   (refclk),
        .i_rst_n (rst_n),
        .i_d     (pll_locked_i),
        .o_q     (w_lock_s)
    );

    assign w_exhausted = (r_retry == RETRY_MAX);

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= PLL_RST;
            r_cnt     <= '0;
            r_stable  <= '0;
            r_timeout <= '0;
            r_retry   <= '0;
            r_pll_rst <= 1'b1;
            r_dom     <= '0;
            r_ready   <= 1'b0;
            r_fail    <= 1'b0;
            r_lol     <= 1'b0;
        end else begin
            r_lol <= 1'b0;
            unique case (r_state)
                PLL_RST: begin
                    if (r_cnt == PULSE_LAST) begin
                        r_state   <= WAIT_LOCK;
                        r_pll_rst <= 1'b0;
                        r_cnt     <= '0;
                        r_stable  <= '0;
                        r_timeout <= '0;
                    end else begin
                        r_cnt <= r_cnt + PW'(1);
                    end
                end
                WAIT_LOCK: begin
                    // A lock that matures on the timeout cycle still wins.
                    if (w_lock_s && r_stable == STABLE_LAST) begin
                        r_state <= RELEASE;
                        r_dom   <= DOM_ONE;
                        r_cnt   <= '0;
                    end else if (r_timeout == TOUT_LAST) begin
                        if (w_exhausted) begin
                            r_state <= FAIL;
                            r_fail  <= 1'b1;
                        end else begin
                            r_state   <= PLL_RST;
                            r_retry   <= r_retry + CW'(1);
                            r_pll_rst <= 1'b1;
                            r_cnt     <= '0;
                        end
                    end else begin
                        r_timeout <= r_timeout + TW'(1);
                        r_stable  <= w_lock_s ? r_stable + SW'(1) : '0;
                    end
                end
                RELEASE: begin
                    if (!w_lock_s) begin
                        r_lol <= 1'b1;
                        r_dom <= '0;
                        if (w_exhausted) begin
                            r_state <= FAIL;
                            r_fail  <= 1'b1;
                        end else begin
                            r_state   <= PLL_RST;
                            r_retry   <= r_retry + CW'(1);
                            r_pll_rst <= 1'b1;
                            r_cnt     <= '0;
                        end
                    end else if (r_dom[NUM_DOMAINS-1]) begin
                        r_state <= RUN;
                        r_ready <= 1'b1;
                        r_retry <= '0;
                    end else if (r_cnt == STAG_LAST) begin
                        // Domains release in index order, so the
                        // released set is a growing thermometer code.
                        r_cnt <= '0;
                        r_dom <= (r_dom << 1) | DOM_ONE;
                    end else begin
                        r_cnt <= r_cnt + PW'(1);
                    end
                end
                RUN: begin
                    if (restart_i || !w_lock_s) begin
                        r_lol     <= !restart_i;
                        r_state   <= PLL_RST;
                        r_dom     <= '0;
                        r_ready   <= 1'b0;
                        r_pll_rst <= 1'b1;
                        r_retry   <= '0;
                        r_cnt     <= '0;
                    end
                end
                FAIL: begin
                    if (restart_i) begin
                        r_state   <= PLL_RST;
                        r_fail    <= 1'b0;
                        r_retry   <= '0;
                        r_pll_rst <= 1'b1;
                        r_cnt     <= '0;
                    end
                end
                default: begin
                    r_state   <= PLL_RST;
                    r_dom     <= '0;
                    r_ready   <= 1'b0;
                    r_pll_rst <= 1'b1;
                    r_cnt     <= '0;
                end
            endcase
        end
    end

    assign pll_rst_o      = r_pll_rst;
    assign domain_rst_n_o = r_dom;
    assign ready_o        = r_ready;
    assign fail_o         = r_fail;
    assign lol_event_o    = r_lol;
    assign retry_cnt_o    = r_retry;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: directed scenarios push expected output changes
// (cycle + full output snapshot) into a queue; a monitor checks every change.
module tb_pll_reset_sequencer;

    localparam int TOUT = 3000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       restart;
    logic       pll_rst;
    logic [3:0] dom;
    logic       rdy;
    logic       fl;
    logic       lol;
    logic [1:0] rty;

    int         cyc = 0;
    logic [9:0] exp_q[$];
    int         cyc_q[$];
    string      name_q[$];
    logic [9:0] snap;
    logic [9:0] prev = 'x;
    logic [9:0] ew;
    int         ec;
    string      en;
    int         n_chk = 0;
    int         n_pass = 0;
    bit         done = 1'b0;

    logic       e_pll;
    logic [3:0] e_dom;
    logic       e_rdy;
    logic       e_fl;
    logic       e_lol;
    logic [1:0] e_rty;

    pll_reset_sequencer #(
        .LOCK_TIMEOUT_CYC (TOUT)
    ) dut (
        .refclk         (clk),
        .rst_n          (rst_n),
        .pll_locked_i   (pll_locked),
        .restart_i      (restart),
        .pll_rst_o      (pll_rst),
        .domain_rst_n_o (dom),
        .ready_o        (rdy),
        .fail_o         (fl),
        .lol_event_o    (lol),
        .retry_cnt_o    (rty)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic ev(input string nm, input int c);
        exp_q.push_back({e_pll, e_dom, e_rdy, e_fl, e_lol, e_rty});
        cyc_q.push_back(c);
        name_q.push_back(nm);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_reset_vals();
        e_pll = 1'b1;
        e_dom = 4'b0000;
        e_rdy = 1'b0;
        e_fl  = 1'b0;
        e_lol = 1'b0;
        e_rty = 2'd0;
    endtask

    task automatic push_release(input int d);
        e_dom = 4'b0001; ev("dom0", d);
        e_dom = 4'b0011; ev("dom1", d + 8);
        e_dom = 4'b0111; ev("dom2", d + 16);
        e_dom = 4'b1111; ev("dom3", d + 24);
        e_rdy = 1'b1;
        e_rty = 2'd0;
        ev("ready", d + 25);
    endtask

    // Lock rises 50 cycles after the PLL reset falls at cycle f.
    task automatic clean_lock(input int f);
        int d;
        d = f + 1076;
        push_release(d);
        wait_cyc(f + 50);
        pll_locked = 1'b1;
        wait_cyc(d + 30);
    endtask

    // From RUN: lock drops and restart arrives on the same FSM edge.
    task automatic restart_seq(output int f);
        int q;
        q = cyc;
        e_pll = 1'b1;
        e_dom = 4'b0000;
        e_rdy = 1'b0;
        ev("restart", q + 3);
        e_pll = 1'b0;
        ev("pllfall", q + 19);
        f = q + 19;
        pll_locked = 1'b0;
        wait_cyc(q + 2);
        restart = 1'b1;
        wait_cyc(q + 3);
        restart = 1'b0;
    endtask

    initial begin
        int f;
        int d;
        int p;
        int l;
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        restart    = 1'b0;
        set_reset_vals();
        ev("rstval", 1);
        wait_cyc(4);
        rst_n = 1'b1;
        e_pll = 1'b0;
        ev("pllfall", 20);
        clean_lock(20);

        // lock loss in RUN, then lock loss mid-RELEASE
        l = cyc;
        e_pll = 1'b1; e_dom = 4'b0000; e_rdy = 1'b0; e_lol = 1'b1;
        ev("lol_run", l + 3);
        e_lol = 1'b0; ev("lol_end", l + 4);
        e_pll = 1'b0; ev("pllfall", l + 19);
        pll_locked = 1'b0;
        f = l + 19;
        d = f + 1076;
        e_dom = 4'b0001; ev("dom0", d);
        e_dom = 4'b0011; ev("dom1", d + 8);
        e_pll = 1'b1; e_dom = 4'b0000; e_lol = 1'b1; e_rty = 2'd1;
        ev("lol_rel", d + 12);
        e_lol = 1'b0; ev("lol_end", d + 13);
        e_pll = 1'b0; ev("pllfall", d + 28);
        wait_cyc(f + 50);
        pll_locked = 1'b1;
        wait_cyc(d + 9);
        pll_locked = 1'b0;
        clean_lock(d + 28);

        // restart beats lock loss; glitch at stable count 1000
        restart_seq(f);
        push_release(f + 2077);
        wait_cyc(f + 50);
        pll_locked = 1'b1;
        wait_cyc(f + 1050);
        pll_locked = 1'b0;
        wait_cyc(f + 1051);
        pll_locked = 1'b1;
        wait_cyc(f + 2077 + 30);

        // never locks: four attempts, then FAIL
        restart_seq(f);
        p = f;
        for (int n = 1; n <= 3; n++) begin
            e_pll = 1'b1; e_rty = 2'(n); ev("tout", p + TOUT);
            p = p + TOUT + 16;
            e_pll = 1'b0; ev("pllfall", p);
        end
        e_fl = 1'b1; ev("fail", p + TOUT);
        wait_cyc(p + TOUT + 5);
        pll_locked = 1'b1;
        wait_cyc(p + TOUT + 25);
        pll_locked = 1'b0;
        e_pll = 1'b1; e_fl = 1'b0; e_rty = 2'd0;
        ev("restart_fail", p + TOUT + 41);
        e_pll = 1'b0; ev("pllfall", p + TOUT + 57);
        wait_cyc(p + TOUT + 40);
        restart = 1'b1;
        wait_cyc(p + TOUT + 41);
        restart = 1'b0;
        clean_lock(p + TOUT + 57);

        // async reset in the middle of RELEASE
        restart_seq(f);
        d = f + 1076;
        e_dom = 4'b0001; ev("dom0", d);
        e_dom = 4'b0011; ev("dom1", d + 8);
        wait_cyc(f + 50);
        pll_locked = 1'b1;
        wait_cyc(d + 10);
        set_reset_vals();
        ev("arst", d + 10);
        rst_n = 1'b0;
        pll_locked = 1'b0;
        wait_cyc(d + 20);
        rst_n = 1'b1;
        e_pll = 1'b0; ev("pllfall", d + 36);
        clean_lock(d + 36);
        done = 1'b1;
    end

    always @(negedge clk) begin
        snap = {pll_rst, dom, rdy, fl, lol, rty};
        if (snap !== prev) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected: got %b at cyc %0d, want no change",
                         snap, cyc);
            end else begin
                ew = exp_q.pop_front();
                ec = cyc_q.pop_front();
                en = name_q.pop_front();
                if (snap !== ew || cyc != ec)
                    $display("FAIL %s: got %b at cyc %0d, want %b at cyc %0d",
                             en, snap, cyc, ew, ec);
                else
                    n_pass++;
            end
            prev = snap;
        end
        if (done || cyc > 40000) begin
            n_chk++;
            if (!done)
                $display("FAIL watchdog: got cyc %0d, want done before 40000",
                         cyc);
            else if (exp_q.size() != 0)
                $display("FAIL leftover: got %0d pending (next %s), want 0",
                         exp_q.size(), name_q[0]);
            else
                n_pass++;
            $display("%0d/%0d checks passed", n_pass, n_chk);
            $finish;
        end
    end

endmodule
